// File: rtl/clk_divider_prog_if.sv
// rtl/clk_divider_prog_if.sv - control and output bundle for the programmable clock divider
interface clk_divider_prog_if #(
   parameter int DIV_W = 8
);
   logic             en_i;
   logic [DIV_W-1:0] div_i;
   logic             load_i;
   logic             clk_o;
   logic             tick_o;
   logic             pend_o;

   // controller side: drives run enable and ratio loads, observes the divided clock
   modport master (
      output en_i,
      output div_i,
      output load_i,
      input  clk_o,
      input  tick_o,
      input  pend_o
   );

   // divider side
   modport slave (
      input  en_i,
      input  div_i,
      input  load_i,
      output clk_o,
      output tick_o,
      output pend_o
   );
endinterface

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - programmable integer clock divider; CLK_DIV_ODD_DUTY50_EN adds 50% duty for odd ratios
module clk_divider_prog #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst,
   clk_divider_prog_if.slave bus
);

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   typedef enum logic {
      ST_PARK = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] act_div_q, act_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q, pend_d;
   logic             clk_o_q, clk_o_d;
   logic             tick_q, tick_d;

   logic [DIV_W-1:0] div_sat;
   logic [DIV_W-1:0] half_div;
   logic             last_cyc;
   logic             boundary;
   logic             start;

   // ratios below 2 cannot produce a toggling clock, so they are promoted to 2
   always_comb begin
      div_sat = (bus.div_i < TWO) ? TWO : bus.div_i;
   end

   // next-state: period counter, park/run control, ratio hand-over at period boundaries
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      boundary   = 1'b0;
      start      = 1'b0;
      last_cyc   = (cnt_q == (act_div_q - ONE));

      case (state_q)
         ST_PARK: begin
            // a parked divider is already at a period boundary
            if (bus.en_i) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               boundary = 1'b1;
               start    = 1'b1;
            end
         end
         ST_RUN: begin
            if (last_cyc) begin
               cnt_d    = '0;
               boundary = 1'b1;
               // enable is only honoured at the end of a period so no phase is cut short
               if (bus.en_i) begin
                  start = 1'b1;
               end else begin
                  state_d = ST_PARK;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = ST_PARK;
            cnt_d   = '0;
         end
      endcase

      // hand-over uses the pending value from before this cycle, so a load landing
      // on the boundary itself waits for the next boundary
      if (boundary && pend_q) begin
         act_div_d = pend_div_q;
         pend_d    = 1'b0;
      end

      if (bus.load_i) begin
         pend_div_d = div_sat;
         pend_d     = 1'b1;
      end

      // the high phase is judged against the ratio that governs the new cycle
      half_div = act_div_d >> 1;
      clk_o_d  = (state_d == ST_RUN) && (cnt_d < half_div);
      tick_d   = start;
   end

   // state register with asynchronous reset to the parked default-ratio state
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q    <= ST_PARK;
         cnt_q      <= '0;
         act_div_q  <= DEF_DIV;
         pend_div_q <= DEF_DIV;
         pend_q     <= 1'b0;
         clk_o_q    <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         act_div_q  <= act_div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
         clk_o_q    <= clk_o_d;
         tick_q     <= tick_d;
      end
   end

`ifdef CLK_DIV_ODD_DUTY50_EN
   logic ext_q, ext_d;

   // for odd ratios, hold the output high for an extra half source period
   // by catching the last high cycle on the falling edge
   always_comb begin
      ext_d = act_div_q[0] && clk_o_q && (cnt_q == ((act_div_q >> 1) - ONE));
   end

   // falling-edge stretch flop, cleared with the rest of the divider
   always_ff @(negedge clk_i or posedge rst) begin
      if (rst) begin
         ext_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
      end
   end

   assign bus.clk_o = clk_o_q | ext_q;
`else
   assign bus.clk_o = clk_o_q;
`endif

   assign bus.tick_o = tick_q;
   assign bus.pend_o = pend_q;

endmodule
